// File: rtl/alu_sequencer.sv
// Multi-cycle controller owning AC, R and the zero flag: sequences the external 8-bit ALU
// and moves data between the registers and memory, one command at a time.
module alu_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic [7:0]        alu_ac,
   output logic [7:0]        alu_r,
   output logic [2:0]        alu_sel,
   input  logic [7:0]        alu_result,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [7:0]        ac_out,
   output logic              zero,
   output logic              done,
   output logic              err
);
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [3:0] OP_LDAC = 4'b1000;
   localparam logic [3:0] OP_STAC = 4'b1001;
   localparam logic [3:0] OP_MVAC = 4'b1010;
   localparam logic [3:0] OP_MOVR = 4'b1011;
   localparam logic [3:0] OP_LDR  = 4'b1100;

   typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

   state_t           state, state_next;
   logic [3:0]       op;
   logic [7:0]       ac, r;
   logic [CNT_W-1:0] cnt;
   logic             accept, is_exec, is_mem, is_illegal, timeout;
   logic             done_next, err_next;
   logic             ac_we, r_we;
   logic [7:0]       ac_wdata, r_wdata;

   assign accept     = cmd_valid && (state == IDLE);
   assign is_exec    = !cmd_op[3] || (cmd_op == OP_MVAC) || (cmd_op == OP_MOVR);
   assign is_mem     = (cmd_op == OP_LDAC) || (cmd_op == OP_STAC) || (cmd_op == OP_LDR);
   assign is_illegal = !is_exec && !is_mem;
   // Expires on the last allowed MEM cycle; an ack in that same cycle still wins.
   assign timeout    = (MEM_TIMEOUT != 0) && (state == MEM) && !mem_ack &&
                       (cnt == CNT_W'(MEM_TIMEOUT - 1));

   assign alu_ac    = ac;
   assign alu_r     = r;
   assign ac_out    = ac;
   assign mem_wdata = ac;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && is_exec)     state_next = EXEC;
            else if (accept && is_mem) state_next = MEM;
         end
         EXEC:    state_next = IDLE;
         MEM:     if (mem_ack || timeout) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      done_next = 1'b0;
      err_next  = 1'b0;
      ac_we     = 1'b0;
      r_we      = 1'b0;
      ac_wdata  = alu_result;
      r_wdata   = ac;
      case (state)
         IDLE: err_next = accept && is_illegal;
         EXEC: begin
            done_next = 1'b1;
            if (!op[3]) begin
               ac_we = 1'b1;
            end else if (op == OP_MVAC) begin
               r_we = 1'b1;
            end else begin
               ac_we    = 1'b1;
               ac_wdata = r;
            end
         end
         MEM: begin
            if (mem_ack) begin
               done_next = 1'b1;
               ac_we     = (op == OP_LDAC);
               r_we      = (op == OP_LDR);
               ac_wdata  = mem_rdata;
               r_wdata   = mem_rdata;
            end else if (timeout) begin
               err_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op       <= '0;
         ac       <= '0;
         r        <= '0;
         zero     <= 1'b0;
         alu_sel  <= '0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= done_next;
         err  <= err_next;
         if (accept) begin
            op <= cmd_op;
            if (!cmd_op[3]) alu_sel <= cmd_op[2:0];
            if (is_mem) begin
               mem_req  <= 1'b1;
               mem_we   <= (cmd_op == OP_STAC);
               mem_addr <= cmd_addr;
               cnt      <= '0;
            end
         end
         if (state == MEM) begin
            if (mem_ack || timeout) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end else if (MEM_TIMEOUT != 0) begin
               cnt <= cnt + CNT_W'(1);
            end
         end
         if (ac_we) begin
            ac   <= ac_wdata;
            zero <= (ac_wdata == 8'h00);
         end
         if (r_we) r <= r_wdata;
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer: a behavioural ALU and memory responder
// drive the DUT while a register-level reference model predicts AC, R, zero and the pulses.
module tb_alu_sequencer;
   localparam int AW  = 16;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [7:0]    alu_ac, alu_r, alu_result;
   logic [2:0]    alu_sel;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic [7:0]    ac_out;
   logic          zero, done, err;

   int checks = 0;
   int errors = 0;
   logic [7:0] ac_m = '0;
   logic [7:0] r_m  = '0;
   logic       z_m  = 1'b0;

   always #5 clk = ~clk;

   alu_sequencer #(.ADDR_W(AW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .alu_ac(alu_ac), .alu_r(alu_r),
      .alu_sel(alu_sel), .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ac_out(ac_out), .zero(zero), .done(done), .err(err)
   );

   function automatic logic [7:0] alu_fn(input logic [2:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a + 8'd1;
         3'd3:    return 8'd0;
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_sel, alu_ac, alu_r);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_ac"}, 32'(ac_out), 32'(ac_m));
      check({tag, "_r"}, 32'(alu_r), 32'(r_m));
      check({tag, "_zero"}, 32'(zero), 32'(z_m));
   endtask

   // ack_cyc: MEM cycle (1-based) in which mem_ack is given; 0 = never.
   task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] addr, input int ack_cyc,
                          input logic [7:0] rdata);
      bit         is_mem, is_ill, acked;
      logic [7:0] ac0;
      is_ill = (op >= 4'hD);
      is_mem = (op == 4'h8) || (op == 4'h9) || (op == 4'hC);
      acked  = (ack_cyc > 0) && (ack_cyc <= TMO);
      ac0    = ac_m;
      check("ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      @(negedge clk);
      if (is_ill) begin
         cmd_valid = 1'b0;
         check("ill_err", 32'(err), 32'd1);
         check("ill_done", 32'(done), 32'd0);
         check("ill_ready", 32'(cmd_ready), 32'd1);
      end else if (!is_mem) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = 4'($urandom);
         cmd_addr  = AW'($urandom);
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = 8'($urandom);
         check("exec_ready", 32'(cmd_ready), 32'd0);
         check("exec_done", 32'(done), 32'd0);
         if (!op[3]) check("alu_sel", 32'(alu_sel), 32'(op[2:0]));
         @(negedge clk);
         cmd_valid = 1'b0;
         mem_ack   = 1'b0;
         check("exec_done2", 32'(done), 32'd1);
         check("exec_err2", 32'(err), 32'd0);
         check("exec_ready2", 32'(cmd_ready), 32'd1);
      end else begin
         for (int k = 1; k <= 40; k++) begin
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(op == 4'h9));
            check("mem_addr", 32'(mem_addr), 32'(addr));
            check("mem_wdata", 32'(mem_wdata), 32'(ac0));
            check("mem_ready", 32'(cmd_ready), 32'd0);
            check("mem_pulse", 32'({done, err}), 32'd0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 4'($urandom);
            if (k == ack_cyc) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (k == ack_cyc || k == TMO) break;
         end
         cmd_valid = 1'b0;
         check("mem_req_end", 32'(mem_req), 32'd0);
         check("mem_done", 32'(done), 32'(acked));
         check("mem_err", 32'(err), 32'(!acked));
         check("mem_ready_end", 32'(cmd_ready), 32'd1);
      end
      case (op)
         4'h8: if (acked) begin ac_m = rdata; z_m = (rdata == 8'h00); end
         4'hA: r_m = ac_m;
         4'hB: begin ac_m = r_m; z_m = (ac_m == 8'h00); end
         4'hC: if (acked) r_m = rdata;
         default: if (!op[3]) begin
            ac_m = alu_fn(op[2:0], ac_m, r_m);
            z_m  = (ac_m == 8'h00);
         end
      endcase
      check_regs($sformatf("op%0h", op));
      $display("cmd op=%h addr=%h ack=%0d -> ac=%h r=%h zero=%0d", op, addr, ack_cyc,
               ac_out, alu_r, zero);
   endtask

   // An idle cycle, optionally with a stray ack that must be ignored.
   task automatic idle_cycle();
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_pulse", 32'({done, err}), 32'd0);
      check("idle_req", 32'(mem_req), 32'd0);
      check_regs("idle");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel, ack;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_req", 32'({mem_req, mem_we}), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_pulse", 32'({done, err}), 32'd0);
      check("rst_sel", 32'(alu_sel), 32'd0);
      check_regs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run_cmd(4'h8, 16'h0010, 2, 8'h05);   // LDAC 5
      run_cmd(4'hC, 16'h0020, 1, 8'h03);   // LDR 3
      run_cmd(4'h0, 16'h0000, 0, 8'h00);   // ADD -> 8
      run_cmd(4'h3, 16'h0000, 0, 8'h00);   // CLAC -> 0
      run_cmd(4'hC, 16'h0021, 1, 8'h01);   // LDR 1
      run_cmd(4'h1, 16'h0000, 0, 8'h00);   // SUB -> FF
      run_cmd(4'h2, 16'h0000, 0, 8'h00);   // INAC -> 00
      run_cmd(4'h3, 16'h0000, 0, 8'h00);   // CLAC -> 00
      run_cmd(4'h8, 16'h0030, 1, 8'h5A);
      run_cmd(4'h9, 16'h1234, 4, 8'h00);   // STAC, ack in 4th MEM cycle
      run_cmd(4'h8, 16'h0040, 0, 8'h77);   // no ack -> timeout
      run_cmd(4'h8, 16'h0041, TMO, 8'h00); // ack on last allowed cycle
      run_cmd(4'hE, 16'h0000, 0, 8'h00);   // illegal
      run_cmd(4'hA, 16'h0000, 0, 8'h00);   // MVAC
      run_cmd(4'hB, 16'h0000, 0, 8'h00);   // MOVR

      // Reset in the middle of a memory read.
      cmd_valid = 1'b1;
      cmd_op    = 4'h8;
      cmd_addr  = 16'h55AA;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_req", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_req", 32'(mem_req), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      ac_m = '0;
      r_m  = '0;
      z_m  = 1'b0;
      check_regs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_cmd(4'h2, 16'h0000, 0, 8'h00);   // INAC after reset -> 1

      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      ack = 0;
         else if (sel == 1) ack = TMO;
         else if (sel == 2) ack = TMO + 1;
         else               ack = $urandom_range(1, 5);
         if ($urandom_range(0, 3) == 0) idle_cycle();
         run_cmd(4'($urandom), AW'($urandom), ack, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
